// File: rtl/stopwatch_input_ctrl.sv
// Stopwatch button front-end: 2-flop sync, per-button debounce, press pulses, run/clear control.
// Optional CLEAR_STOPS_RUN_EN: an accepted clear press also forces run low.
module stopwatch_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_start,
  input  logic btn_clear,
  output logic run,
  output logic clear,
  output logic start_db,
  output logic clear_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Channel 0 is start, channel 1 is clear.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_q;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  assign raw   = {btn_clear, btn_start};
  assign press = db & ~db_q;

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1[ch] <= 1'b0;
        sync2[ch] <= 1'b0;
        db[ch]    <= 1'b0;
        cnt[ch]   <= '0;
      end else begin
        sync1[ch] <= raw[ch];
        sync2[ch] <= sync1[ch];
        // Any cycle that agrees with the accepted level restarts the count.
        if (sync2[ch] == db[ch]) begin
          cnt[ch] <= '0;
        end else if (cnt[ch] == CNT_MAX) begin
          db[ch]  <= sync2[ch];
          cnt[ch] <= '0;
        end else begin
          cnt[ch] <= cnt[ch] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q  <= 2'b00;
      clear <= 1'b0;
      run   <= 1'b0;
    end else begin
      db_q  <= db;
      clear <= press[1];
      if (press[0] && press[1]) begin
        run <= 1'b0;
`ifdef CLEAR_STOPS_RUN_EN
      end else if (press[1]) begin
        run <= 1'b0;
`endif
      end else if (press[0] && !press[1]) begin
        run <= ~run;
      end
    end
  end

  assign start_db = db[0];
  assign clear_db = db[1];

endmodule
